// File: rtl/unisim_sram_b_arbiter_pkg.sv
// Shared sizing and types for the SRAM wrapper and its two-requester arbiter.
package unisim_sram_b_arbiter_pkg;

  localparam int N_REQ = 2;   // requesters on the arbiter
  localparam int AW    = 9;   // SRAM word address width
  localparam int DW    = 8;   // SRAM data width

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;

  // Round-robin pointer: which requester wins a tie on a port.
  typedef enum logic {
    PTR_R0 = 1'b0,
    PTR_R1 = 1'b1
  } rr_ptr_e;

  // Everything the write port of the SRAM needs in one cycle.
  typedef struct packed {
    logic  ce;
    logic  we;
    addr_t a;
    data_t d;
    data_t wem;
  } wr_port_t;

  // Bit-masked merge of new data into an old word.
  function automatic data_t wem_merge(data_t old_w, data_t new_w, data_t wem);
    return (old_w & ~wem) | (new_w & wem);
  endfunction

endpackage

// File: rtl/unisim_sram_b_arbiter_if.sv
// Requester-side bus: request handshake plus the shared read response.
interface unisim_sram_b_arbiter_if;
  import unisim_sram_b_arbiter_pkg::*;

  logic [N_REQ-1:0]         REQ_VALID;
  logic [N_REQ-1:0]         REQ_READY;
  logic [N_REQ-1:0]         REQ_WE;
  logic [N_REQ-1:0][AW-1:0] REQ_A;
  logic [N_REQ-1:0][DW-1:0] REQ_D;
  logic [N_REQ-1:0][DW-1:0] REQ_WEM;
  logic [N_REQ-1:0]         RSP_VALID;
  logic [DW-1:0]            RSP_Q;

  modport master (
    output REQ_VALID, REQ_WE, REQ_A, REQ_D, REQ_WEM,
    input  REQ_READY, RSP_VALID, RSP_Q
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_A, REQ_D, REQ_WEM,
    output REQ_READY, RSP_VALID, RSP_Q
  );

endinterface

// File: rtl/unisim_sram_b_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational from req and the
// pointer; the pointer only moves when the caller says the grant was used
// (adv), so the caller can veto a grant without losing its priority.
module rr_arb2
  import unisim_sram_b_arbiter_pkg::*;
(
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  rr_ptr_e ptr_q, ptr_d;
  logic    pref;

  assign pref = ptr_q;

  // Pointer register, back to requester 0 on reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) ptr_q <= PTR_R0;
    else       ptr_q <= ptr_d;
  end

  // Grant: preferred requester first, otherwise the other one.
  always_comb begin
    gnt = '0;
    if (en) begin
      if (req[pref])       gnt[pref]  = 1'b1;
      else if (req[!pref]) gnt[!pref] = 1'b1;
    end
  end

  // After a used grant, prefer the requester that did not win.
  always_comb begin
    ptr_d = ptr_q;
    if (adv) ptr_d = gnt[0] ? PTR_R1 : PTR_R0;
  end

endmodule

// File: rtl/unisim_sram_b_arbiter.sv
// Arbitrates two requesters onto a 1W/1R SRAM: writes go to port 0, reads
// to port 1, each port with its own round-robin pointer. Read data comes
// back one cycle after grant on a shared bus, tagged by a one-hot valid.
module unisim_sram_b_arbiter
  import unisim_sram_b_arbiter_pkg::*;
#(
  parameter int NREQ = N_REQ
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  unisim_sram_b_arbiter_if.slave  bus,
  output logic                    CE0,
  output logic [AW-1:0]           A0,
  output logic [DW-1:0]           D0,
  output logic                    WE0,
  output logic [DW-1:0]           WEM0,
  output logic                    CE1,
  output logic [AW-1:0]           A1,
  input  logic [DW-1:0]           Q1
);

  logic [NREQ-1:0] wr_req, rd_req;
  logic [NREQ-1:0] wr_gnt, rd_cand, rd_gnt;
  logic [NREQ-1:0] rd_tag_q;
  wr_port_t        wr;
  addr_t           rd_a;
  logic            collide;

  assign wr_req = bus.REQ_VALID &  bus.REQ_WE;
  assign rd_req = bus.REQ_VALID & ~bus.REQ_WE;

  // Arbiters are disabled during reset so nothing is granted then.
  rr_arb2 u_wr_arb (
    .CLK  (CLK),
    .RSTN (RSTN),
    .en   (RSTN),
    .req  (wr_req),
    .adv  (|wr_gnt),
    .gnt  (wr_gnt)
  );

  // Read pointer advances only on a read that really went out.
  rr_arb2 u_rd_arb (
    .CLK  (CLK),
    .RSTN (RSTN),
    .en   (RSTN),
    .req  (rd_req),
    .adv  (|rd_gnt),
    .gnt  (rd_cand)
  );

  // Steer the granted writer onto port 0 and pick the candidate read address.
  always_comb begin
    wr   = '0;
    rd_a = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (wr_gnt[i]) begin
        wr.ce  = 1'b1;
        wr.we  = 1'b1;
        wr.a   = bus.REQ_A[i];
        wr.d   = bus.REQ_D[i];
        wr.wem = bus.REQ_WEM[i];
      end
      if (rd_cand[i]) rd_a = bus.REQ_A[i];
    end
  end

  // A read hitting the word being written this cycle is held off one
  // cycle so it returns the new data instead of racing the write.
  assign collide = wr.ce && (|rd_cand) && (wr.a == rd_a);
  assign rd_gnt  = collide ? '0 : rd_cand;

  assign CE0  = wr.ce;
  assign WE0  = wr.we;
  assign A0   = wr.a;
  assign D0   = wr.d;
  assign WEM0 = wr.wem;

  assign CE1 = |rd_gnt;
  assign A1  = (|rd_gnt) ? rd_a : '0;

  assign bus.REQ_READY = wr_gnt | rd_gnt;

  // Read tag: which requester owns the data coming out of Q1 next cycle.
  always_ff @(posedge CLK) begin
    if (!RSTN) rd_tag_q <= '0;
    else       rd_tag_q <= rd_gnt;
  end

  // Tag is masked during reset so an in-flight read is dropped.
  assign bus.RSP_VALID = rd_tag_q & {NREQ{RSTN}};
  assign bus.RSP_Q     = (|bus.RSP_VALID) ? Q1 : '0;

endmodule

// File: tb/tb_unisim_sram_b_arbiter.sv
// Bench for unisim_sram_b_arbiter: behavioural SRAM, a per-cycle reference
// model of the arbitration rules, and directed scenarios with literal checks.
module tb_unisim_sram_b_arbiter;
  import unisim_sram_b_arbiter_pkg::*;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          CE0, WE0, CE1;
  logic [AW-1:0] A0, A1;
  logic [DW-1:0] D0, WEM0;
  logic [DW-1:0] q1 = '0;

  int n_chk = 0;
  int n_err = 0;

  unisim_sram_b_arbiter_if bus();

  unisim_sram_b_arbiter #(.NREQ(2)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus.slave),
    .CE0  (CE0),
    .A0   (A0),
    .D0   (D0),
    .WE0  (WE0),
    .WEM0 (WEM0),
    .CE1  (CE1),
    .A1   (A1),
    .Q1   (q1)
  );

  always #5 CLK = ~CLK;

  // Synchronous SRAM, 1 write port, 1 read port, read latency 1.
  logic [DW-1:0] sram [512] = '{default: 8'h00};
  always @(posedge CLK) begin
    if (CE1) q1 <= sram[A1];
    if (CE0 && WE0) sram[A0] <= wem_merge(sram[A0], D0, WEM0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory contents, the two preferred requesters and the
  // read response owed next cycle.
  logic [DW-1:0] mmem [512] = '{default: 8'h00};
  int            wp = 0, rp = 0;
  bit            pend = 0;
  int            pend_id = 0;
  logic [DW-1:0] pend_dat = '0;

  always @(negedge CLK) begin
    int wg, rg, k;
    logic [1:0] e_rdy, e_rv;
    if (!RSTN) begin
      chk("m_rst_ready", bus.REQ_READY, 0);
      chk("m_rst_ce0", CE0, 0);
      chk("m_rst_ce1", CE1, 0);
      chk("m_rst_rspv", bus.RSP_VALID, 0);
      chk("m_rst_rspq", bus.RSP_Q, 0);
      wp = 0; rp = 0; pend = 0;
    end else begin
      wg = -1; rg = -1;
      for (int j = 0; j < 2; j++) begin
        k = (j == 0) ? wp : 1 - wp;
        if (wg < 0 && bus.REQ_VALID[k] && bus.REQ_WE[k]) wg = k;
        k = (j == 0) ? rp : 1 - rp;
        if (rg < 0 && bus.REQ_VALID[k] && !bus.REQ_WE[k]) rg = k;
      end
      if (wg >= 0 && rg >= 0 && bus.REQ_A[wg] == bus.REQ_A[rg]) rg = -1;
      e_rdy = '0;
      if (wg >= 0) e_rdy[wg] = 1'b1;
      if (rg >= 0) e_rdy[rg] = 1'b1;
      e_rv = '0;
      if (pend) e_rv[pend_id] = 1'b1;
      chk("m_ready", bus.REQ_READY, e_rdy);
      chk("m_ce0", CE0, wg >= 0);
      chk("m_we0", WE0, wg >= 0);
      chk("m_a0",   A0,   (wg >= 0) ? bus.REQ_A[wg]   : 0);
      chk("m_d0",   D0,   (wg >= 0) ? bus.REQ_D[wg]   : 0);
      chk("m_wem0", WEM0, (wg >= 0) ? bus.REQ_WEM[wg] : 0);
      chk("m_ce1", CE1, rg >= 0);
      chk("m_a1",  A1,  (rg >= 0) ? bus.REQ_A[rg] : 0);
      chk("m_rspv", bus.RSP_VALID, e_rv);
      chk("m_rspq", bus.RSP_Q, pend ? pend_dat : 0);
      pend = (rg >= 0);
      if (rg >= 0) begin
        pend_id  = rg;
        pend_dat = mmem[bus.REQ_A[rg]];
        rp = 1 - rg;
      end
      if (wg >= 0) begin
        mmem[bus.REQ_A[wg]] = wem_merge(mmem[bus.REQ_A[wg]], bus.REQ_D[wg], bus.REQ_WEM[wg]);
        wp = 1 - wg;
      end
    end
  end

  // Apply one cycle of inputs, then wait for the sampling edge.
  task automatic drive(input logic rst, input logic [1:0] v, input logic [1:0] we,
                       input logic [8:0] a0, input logic [8:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] m0, input logic [7:0] m1);
    RSTN = rst;
    bus.REQ_VALID = v;
    bus.REQ_WE = we;
    bus.REQ_A[0] = a0;   bus.REQ_A[1] = a1;
    bus.REQ_D[0] = d0;   bus.REQ_D[1] = d1;
    bus.REQ_WEM[0] = m0; bus.REQ_WEM[1] = m1;
    @(negedge CLK);
  endtask

  task automatic next;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle;
    drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset
    drive(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("rst_ready", bus.REQ_READY, 2'b00);
    chk("rst_rspv", bus.RSP_VALID, 2'b00);
    next;
    drive(0, 2'b11, 2'b00, 9'h001, 9'h002, 0, 0, 0, 0);
    chk("rst_ready_busy", bus.REQ_READY, 2'b00);
    next;

    // both write same cycle, then read back
    drive(1, 2'b11, 2'b11, 9'h010, 9'h020, 8'hAA, 8'h55, 8'hFF, 8'hFF);
    chk("s1_w_ready0", bus.REQ_READY, 2'b01);
    chk("s1_a0_0", A0, 9'h010);
    next;
    drive(1, 2'b10, 2'b10, 9'h010, 9'h020, 8'hAA, 8'h55, 8'hFF, 8'hFF);
    chk("s1_w_ready1", bus.REQ_READY, 2'b10);
    chk("s1_a0_1", A0, 9'h020);
    next;
    drive(1, 2'b11, 2'b00, 9'h010, 9'h020, 0, 0, 0, 0);
    chk("s1_r_ready0", bus.REQ_READY, 2'b01);
    chk("s1_a1", A1, 9'h010);
    next;
    drive(1, 2'b10, 2'b00, 9'h010, 9'h020, 0, 0, 0, 0);
    chk("s1_r_ready1", bus.REQ_READY, 2'b10);
    chk("s1_rspv0", bus.RSP_VALID, 2'b01);
    chk("s1_q0", bus.RSP_Q, 8'hAA);
    next;
    idle;
    chk("s1_rspv1", bus.RSP_VALID, 2'b10);
    chk("s1_q1", bus.RSP_Q, 8'h55);
    next;

    // same-address write/read collision
    drive(1, 2'b11, 2'b01, 9'h005, 9'h005, 8'h3C, 0, 8'hFF, 0);
    chk("s2_ready_col", bus.REQ_READY, 2'b01);
    chk("s2_ce1_col", CE1, 1'b0);
    next;
    drive(1, 2'b10, 2'b00, 9'h005, 9'h005, 0, 0, 0, 0);
    chk("s2_ready_retry", bus.REQ_READY, 2'b10);
    next;
    idle;
    chk("s2_rspv", bus.RSP_VALID, 2'b10);
    chk("s2_q", bus.RSP_Q, 8'h3C);
    next;

    // write and read to different addresses in one cycle
    drive(1, 2'b11, 2'b01, 9'h100, 9'h101, 8'h77, 0, 8'hFF, 0);
    chk("s3_ready", bus.REQ_READY, 2'b11);
    chk("s3_ce", {CE0, CE1}, 2'b11);
    next;
    idle;
    chk("s3_rspv", bus.RSP_VALID, 2'b10);
    next;

    // streaming reads from both requesters
    for (int k = 0; k < 8; k++) begin
      drive(1, 2'b11, 2'b00, 9'h010, 9'h020, 0, 0, 0, 0);
      chk("s4_ready", bus.REQ_READY, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        chk("s4_rspv", bus.RSP_VALID, (k % 2 == 1) ? 2'b01 : 2'b10);
        chk("s4_q", bus.RSP_Q, (k % 2 == 1) ? 8'hAA : 8'h55);
      end
      next;
    end
    idle;
    chk("s4_rspv_last", bus.RSP_VALID, 2'b10);
    chk("s4_q_last", bus.RSP_Q, 8'h55);
    next;

    // partial write mask
    drive(1, 2'b01, 2'b01, 9'h030, 0, 8'hFF, 0, 8'h0F, 0);
    chk("s5_w_ready", bus.REQ_READY, 2'b01);
    chk("s5_wem0", WEM0, 8'h0F);
    next;
    drive(1, 2'b01, 2'b00, 9'h030, 0, 0, 0, 0, 0);
    chk("s5_r_ready", bus.REQ_READY, 2'b01);
    next;
    idle;
    chk("s5_q", bus.RSP_Q, 8'h0F);
    next;

    // reset right after a read grant; pointers were both at r1
    drive(1, 2'b01, 2'b00, 9'h010, 0, 0, 0, 0, 0);
    chk("s6_ready", bus.REQ_READY, 2'b01);
    next;
    drive(0, 2'b11, 2'b00, 9'h010, 9'h020, 0, 0, 0, 0);
    chk("s6_rst_rspv", bus.RSP_VALID, 2'b00);
    chk("s6_rst_ready", bus.REQ_READY, 2'b00);
    next;
    drive(1, 2'b11, 2'b11, 9'h050, 9'h060, 8'h9A, 8'h9B, 8'hFF, 8'hFF);
    chk("s6_post_rspv", bus.RSP_VALID, 2'b00);
    chk("s6_wptr", bus.REQ_READY, 2'b01);
    next;
    drive(1, 2'b11, 2'b00, 9'h050, 9'h060, 0, 0, 0, 0);
    chk("s6_rptr", bus.REQ_READY, 2'b01);
    next;
    idle;
    chk("s6_rspv", bus.RSP_VALID, 2'b01);
    chk("s6_q", bus.RSP_Q, 8'h9A);
    next;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/unisim_sram_b_arbiter.md
UNISIM_SRAM_B_ARBITER -- requirements
Module: unisim_sram_b_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, meaning number of requesters (fixed 2 for this revision).
REQ-002 SHALL have port CLK  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port RSTN  in  1  reset; synchronous, active-low.
REQ-004 SHALL have port REQ_VALID  in  2  per-requester request valid.
REQ-005 SHALL have port REQ_READY  out  2  per-requester grant; transfer occurs when VALID&READY.
REQ-006 SHALL have port REQ_WE  in  2  per-requester op: 1 write, 0 read.
REQ-007 SHALL have port REQ_A  in  2x9  per-requester word address.
REQ-008 SHALL have port REQ_D  in  2x8  per-requester write data.
REQ-009 SHALL have port REQ_WEM  in  2x8  per-requester bit write mask.
REQ-010 SHALL have port RSP_VALID  out  2  per-requester read-data valid, one-cycle pulse.
REQ-011 SHALL have port RSP_Q  out  8  read data, shared, qualified by RSP_VALID.
REQ-012 SHALL have ports CE0, A0[8:0], D0[7:0], WE0, WEM0[7:0]  out  SRAM write port.
REQ-013 SHALL have ports CE1, A1[8:0]  out, Q1[7:0]  in  SRAM read port.

Function
REQ-014 SHALL route all writes to port 0 and all reads to port 1; at most one write and one read granted per cycle.
REQ-015 SHALL arbitrate each port independently with a round-robin pointer: pointer holds the preferred requester; after a grant on that port the pointer moves to the other requester.
REQ-016 SHALL drive CE0=1, WE0=1, A0/D0/WEM0 from the granted writer in the grant cycle, combinationally from REQ_* and pointer state; otherwise CE0=WE0=0 and A0/D0/WEM0=0.
REQ-017 SHALL drive CE1=1, A1 from the granted reader in the grant cycle; otherwise CE1=0, A1=0.
REQ-018 SHALL, when the granted write and the candidate read target the same address in one cycle, deny the read (READY=0) and leave the read pointer unchanged; the write proceeds.
REQ-019 SHALL register a one-hot read tag at grant; next cycle assert RSP_VALID for that requester only, with RSP_Q=Q1 (latency 1); RSP_Q=0 when no RSP_VALID.
REQ-020 SHALL accept no response backpressure; requesters sink RSP_VALID unconditionally.
REQ-021 SHALL allow a requester granted a read to issue a new read the next cycle; tags pipeline back-to-back at one read per cycle.
REQ-022 SHALL never assert READY to a requester with VALID=0, and REQ_READY SHALL be combinational from VALID, WE, A and pointers.
REQ-023 SHALL guarantee no requester waits more than 2 cycles for a given port while the other requester's address never collides.

Reset
REQ-024 SHALL, while RSTN=0 at posedge, set both pointers to requester 0 and clear the read tag.
REQ-025 SHALL hold REQ_READY=0, CE0=CE1=0, RSP_VALID=0 in every cycle RSTN=0.
REQ-026 SHALL drop a read granted in the cycle before reset assertion: no RSP_VALID is produced after reset.

Structure
REQ-027 SHALL place address width (9), data width (8) and requester count in a shared package used by the SRAM wrapper and this block.
REQ-028 SHALL instantiate one sub-module, rr_arb2, a 2-way round-robin arbiter with enable/grant/advance, used twice (write port, read port).
REQ-029 SHALL connect to unisim_sram_b_9abits directly; no extra pipeline stage between arbiter outputs and SRAM ports.

Verification
REQ-030 SHALL cover: both write (0x010/0xAA, 0x020/0x55, WEM=0xFF) same cycle -> r0 granted cycle 1, r1 cycle 2; reads return 0xAA, 0x55.
REQ-031 SHALL cover: r0 writes 0x005 while r1 reads 0x005 -> r1 READY=0 that cycle, granted next, RSP_Q=new data.
REQ-032 SHALL cover: r0 write 0x100, r1 read 0x101 same cycle -> both granted, RSP_VALID[1] one cycle later.
REQ-033 SHALL cover: both stream reads 8 cycles -> grants alternate r0,r1,..., one RSP_VALID per cycle to correct tag.
REQ-034 SHALL cover: WEM=0x0F write 0xFF over 0x00 -> readback 0x0F.
REQ-035 SHALL cover: RSTN=0 one cycle after read grant -> no RSP_VALID; pointers reset to r0.
